// File: rtl/par2ser_dbuf.sv
// Parallel-to-serial converter with a one-word holding buffer.
// A word is either loaded straight into the shifter, or parked in the
// holding stage while the shifter drains. The held word is handed over
// on the edge where the last beat advances, so consecutive words stream
// without an idle cycle.
module par2ser_dbuf #(
  parameter int PW = 64,
  parameter int SW = 1,
  parameter int NB = PW / SW,
  parameter int CW = $clog2(NB) + 1
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          valid_in,
  input  logic [PW-1:0] din,
  input  logic [7:0]    datasize,
  input  logic          lsbfirst,
  input  logic          fill,
  output logic          ready_out,
  input  logic          wait_in,
  output logic [SW-1:0] dout,
  output logic          valid_out,
  output logic          last_out,
  output logic          busy
);

  // Shifter stage
  logic [PW-1:0] shiftreg;
  logic [CW-1:0] count;
  logic          sh_lsb;
  logic          sh_fill;

  // Holding stage
  logic [PW-1:0] hold_word;
  logic [CW-1:0] hold_size;
  logic          hold_lsb;
  logic          hold_fill;
  logic          hold_valid;

  logic          accept;
  logic          adv;
  logic          shift_free;
  logic          load_from_hold;
  logic          load_from_in;
  logic          load_hold;
  logic [CW-1:0] in_size;
  logic [PW-1:0] shift_next;

  // 0 or anything beyond the word length means a full word.
  function automatic logic [CW-1:0] resolve_size(input logic [7:0] ds);
    if (ds == 8'd0 || int'(ds) > NB) return CW'(NB);
    else return CW'(ds);
  endfunction

  // Handshake and shifter-load decisions
  always_comb begin
    accept         = valid_in & ready_out;
    adv            = valid_out & ~wait_in;
    shift_free     = (count == '0) | ((count == CW'(1)) & adv);
    // ready_out is 0 whenever hold_valid is set, so accept never
    // coincides with a hand-over from the holding stage.
    load_from_hold = hold_valid & shift_free;
    load_from_in   = accept & ~hold_valid & shift_free;
    load_hold      = accept & ~shift_free;
    in_size        = resolve_size(datasize);
  end

  // Next shifter contents on a beat advance, back-filling the vacated end
  always_comb begin
    shift_next = shiftreg;
    if (sh_lsb)
      shift_next = (shiftreg >> SW) | ({PW{sh_fill}} & ~({PW{1'b1}} >> SW));
    else
      shift_next = (shiftreg << SW) | ({PW{sh_fill}} & ~({PW{1'b1}} << SW));
  end

  // Shifter register: a load wins over a shift on the same edge
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      shiftreg <= '0;
      count    <= '0;
      sh_lsb   <= 1'b0;
      sh_fill  <= 1'b0;
    end else if (load_from_hold) begin
      shiftreg <= hold_word;
      count    <= hold_size;
      sh_lsb   <= hold_lsb;
      sh_fill  <= hold_fill;
    end else if (load_from_in) begin
      shiftreg <= din;
      count    <= in_size;
      sh_lsb   <= lsbfirst;
      sh_fill  <= fill;
    end else if (adv) begin
      shiftreg <= shift_next;
      count    <= count - CW'(1);
    end
  end

  // Holding stage: filled while the shifter is busy, emptied on hand-over
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      hold_word  <= '0;
      hold_size  <= '0;
      hold_lsb   <= 1'b0;
      hold_fill  <= 1'b0;
      hold_valid <= 1'b0;
    end else if (load_from_hold) begin
      hold_valid <= 1'b0;
    end else if (load_hold) begin
      hold_word  <= din;
      hold_size  <= in_size;
      hold_lsb   <= lsbfirst;
      hold_fill  <= fill;
      hold_valid <= 1'b1;
    end
  end

  // Outputs are pure functions of state
  always_comb begin
    ready_out = ~hold_valid;
    valid_out = (count != '0);
    last_out  = (count == CW'(1));
    busy      = valid_out | hold_valid;
    dout      = sh_lsb ? shiftreg[SW-1:0] : shiftreg[PW-1 -: SW];
  end

endmodule

// File: tb/tb_par2ser_dbuf.sv
// Directed bench for par2ser_dbuf: one 8-bit/1-bit instance and one
// 8-bit/2-bit instance. Inputs change on the falling edge, outputs are
// sampled on the falling edge.
module tb_par2ser_dbuf;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;

  logic       valid_in = 1'b0;
  logic [7:0] din = '0;
  logic [7:0] datasize = '0;
  logic       lsbfirst = 1'b0;
  logic       fill = 1'b0;
  logic       wait_in = 1'b0;
  logic       ready_out;
  logic [0:0] dout;
  logic       valid_out;
  logic       last_out;
  logic       busy;

  logic       valid_in2 = 1'b0;
  logic [7:0] din2 = '0;
  logic [7:0] datasize2 = '0;
  logic       lsbfirst2 = 1'b0;
  logic       fill2 = 1'b0;
  logic       wait_in2 = 1'b0;
  logic       ready_out2;
  logic [1:0] dout2;
  logic       valid_out2;
  logic       last_out2;
  logic       busy2;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  par2ser_dbuf #(.PW(8), .SW(1)) u1 (
    .clk(clk), .nreset(nreset), .valid_in(valid_in), .din(din),
    .datasize(datasize), .lsbfirst(lsbfirst), .fill(fill),
    .ready_out(ready_out), .wait_in(wait_in), .dout(dout),
    .valid_out(valid_out), .last_out(last_out), .busy(busy)
  );

  par2ser_dbuf #(.PW(8), .SW(2)) u2 (
    .clk(clk), .nreset(nreset), .valid_in(valid_in2), .din(din2),
    .datasize(datasize2), .lsbfirst(lsbfirst2), .fill(fill2),
    .ready_out(ready_out2), .wait_in(wait_in2), .dout(dout2),
    .valid_out(valid_out2), .last_out(last_out2), .busy(busy2)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Present one word on u1 for exactly one rising edge.
  task automatic send1(input logic [7:0] d, input logic [7:0] ds, input logic lsb, input logic f);
    @(negedge clk);
    valid_in = 1'b1; din = d; datasize = ds; lsbfirst = lsb; fill = f;
    @(posedge clk);
    #1 valid_in = 1'b0;
  endtask

  logic [7:0] w;
  int         idx [11] = '{0, 1, 2, 3, 3, 3, 3, 4, 5, 6, 7};
  logic [1:0] exp2 [3] = '{2'b11, 2'b00, 2'b01};
  bit         seen;

  initial begin
    // Reset values
    #2;
    check_val("rst_valid", valid_out, 0);
    check_val("rst_last", last_out, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_ready", ready_out, 1);
    check_val("rst_dout", dout, 0);
    @(negedge clk); @(negedge clk);
    nreset = 1'b1;

    // 8'hA5, full word, LSB first
    w = 8'hA5;
    send1(w, 8'd0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_val($sformatf("a5_dout%0d", i), dout, w[i]);
      check_val($sformatf("a5_last%0d", i), last_out, (i == 7));
      check_val($sformatf("a5_valid%0d", i), valid_out, 1);
    end
    @(negedge clk);
    check_val("a5_end_valid", valid_out, 0);

    // SW=2: 8'hC6, 3 beats, MSB first, fill 1
    @(negedge clk);
    valid_in2 = 1'b1; din2 = 8'hC6; datasize2 = 8'd3; lsbfirst2 = 1'b0; fill2 = 1'b1;
    @(posedge clk);
    #1 valid_in2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val($sformatf("c6_dout%0d", i), dout2, exp2[i]);
      check_val($sformatf("c6_last%0d", i), last_out2, (i == 2));
    end
    @(negedge clk);
    check_val("c6_end_valid", valid_out2, 0);

    // Back-to-back FF then 00 with valid_in held high
    @(negedge clk);
    valid_in = 1'b1; din = 8'hFF; datasize = 8'd0; lsbfirst = 1'b1; fill = 1'b0;
    @(posedge clk);
    #1 din = 8'h00;
    @(negedge clk);
    check_val("b2b_dout0", dout, 1);
    check_val("b2b_ready0", ready_out, 1);
    @(posedge clk);
    #1 valid_in = 1'b0;
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      check_val($sformatf("b2b_valid%0d", i), valid_out, 1);
      check_val($sformatf("b2b_dout%0d", i), dout, (i < 8));
      check_val($sformatf("b2b_last%0d", i), last_out, (i == 7 || i == 15));
      check_val($sformatf("b2b_ready%0d", i), ready_out, !(i >= 1 && i <= 7));
      check_val($sformatf("b2b_busy%0d", i), busy, 1);
    end
    @(negedge clk);
    check_val("b2b_end_valid", valid_out, 0);
    check_val("b2b_end_busy", busy, 0);

    // Stall for 3 cycles on the 4th beat
    w = 8'h96;
    send1(w, 8'd0, 1'b1, 1'b0);
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      check_val($sformatf("wait_dout%0d", k), dout, w[idx[k]]);
      check_val($sformatf("wait_last%0d", k), last_out, (k == 10));
      check_val($sformatf("wait_valid%0d", k), valid_out, 1);
      if (k == 3) wait_in = 1'b1;
      if (k == 6) wait_in = 1'b0;
    end
    @(negedge clk);
    check_val("wait_end_valid", valid_out, 0);

    // Oversized datasize clamps to 8 beats
    w = 8'h0F;
    send1(w, 8'd200, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_val($sformatf("ds200_valid%0d", i), valid_out, 1);
      check_val($sformatf("ds200_dout%0d", i), dout, w[i]);
      check_val($sformatf("ds200_last%0d", i), last_out, (i == 7));
    end
    @(negedge clk);
    check_val("ds200_end_valid", valid_out, 0);

    // Reset at beat 3 with a second word held
    @(negedge clk);
    valid_in = 1'b1; din = 8'hFF; datasize = 8'd0; lsbfirst = 1'b1; fill = 1'b0;
    @(posedge clk);
    #1 din = 8'h00;
    @(posedge clk);
    #1 valid_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_val("mid_dout", dout, 1);
    check_val("mid_ready", ready_out, 0);
    nreset = 1'b0;
    #1;
    check_val("mrst_valid", valid_out, 0);
    check_val("mrst_last", last_out, 0);
    check_val("mrst_busy", busy, 0);
    check_val("mrst_ready", ready_out, 1);
    check_val("mrst_dout", dout, 0);
    @(negedge clk); @(negedge clk);
    nreset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (valid_out || busy) seen = 1'b1;
    end
    check_val("post_rst_idle", seen, 0);

    // First valid_in after release is taken on the first rising edge
    @(negedge clk);
    nreset = 1'b0;
    valid_in = 1'b1; din = 8'h81; datasize = 8'd2; lsbfirst = 1'b1; fill = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
    @(negedge clk);
    check_val("rel_valid0", valid_out, 1);
    check_val("rel_dout0", dout, 1);
    check_val("rel_last0", last_out, 0);
    @(negedge clk);
    check_val("rel_dout1", dout, 0);
    check_val("rel_last1", last_out, 1);
    @(negedge clk);
    check_val("rel_end_valid", valid_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/par2ser_dbuf.md
PAR2SER_DBUF -- requirements
Module: par2ser_dbuf

Interface
REQ-001 Parameter PW, default 64, parallel word width in bits.
REQ-002 Parameter SW, default 1, serial beat width in bits; PW SHALL be an integer multiple of SW.
REQ-003 Parameter NB, default PW/SW, maximum beats per word.
REQ-004 Parameter CW, default $clog2(NB)+1, beat counter width, sized to hold NB.
REQ-005 clk  input  1  sampling clock; all state SHALL update on its rising edge.
REQ-006 nreset  input  1  reset, asynchronous assert, active low.
REQ-007 valid_in  input  1  din and its sideband inputs are valid.
REQ-008 din  input  PW  parallel word.
REQ-009 datasize  input  8  beats to send for this word; 0 or any value above NB SHALL mean NB.
REQ-010 lsbfirst  input  1  beat order for this word: 1 = LSB beat first, 0 = MSB beat first.
REQ-011 fill  input  1  bit shifted into vacated positions for this word.
REQ-012 ready_out  output  1  block can accept a word this cycle.
REQ-013 wait_in  input  1  downstream stall; the current beat holds while wait_in = 1.
REQ-014 dout  output  SW  serial beat.
REQ-015 valid_out  output  1  dout is valid.
REQ-016 last_out  output  1  dout is the final beat of its word.
REQ-017 busy  output  1  shifter or holding buffer is occupied.

Function
REQ-018 Storage: one shifter stage (shiftreg, count, latched lsbfirst and fill) and one holding stage (word, size, lsbfirst, fill, hold_valid).
REQ-019 ready_out SHALL equal ~hold_valid, driven combinationally from state only and never from valid_in.
REQ-020 A word is accepted when valid_in & ready_out; din, datasize, lsbfirst and fill SHALL be captured together on that edge.
REQ-021 Beat advance: adv = valid_out & ~wait_in.
REQ-022 The shifter is free when count == 0, or when count == 1 & adv.
REQ-023 On an accepted word, with the holding stage empty and the shifter free, the word SHALL load directly into the shifter; the first beat SHALL appear on dout in the next cycle (1-cycle latency).
REQ-024 On an accepted word with the shifter not free, the word SHALL load into the holding stage.
REQ-025 With the holding stage valid and the shifter free, the held word SHALL move to the shifter and hold_valid SHALL clear on the same edge.
REQ-026 Under REQ-025, the next word's first beat SHALL follow the previous last beat with no idle cycle.
REQ-027 Accepting a word while the holding stage is draining SHALL NOT occur, because ready_out was 0 in that cycle.
REQ-028 count loads the resolved datasize on shifter load; it decrements by 1 on adv; it SHALL never underflow.
REQ-029 valid_out SHALL equal (count != 0).
REQ-030 last_out SHALL equal (count == 1).
REQ-031 busy SHALL equal valid_out | hold_valid.
REQ-032 dout SHALL be shiftreg[SW-1:0] when latched lsbfirst = 1, else shiftreg[PW-1:PW-SW].
REQ-033 On adv with latched lsbfirst = 1, shiftreg SHALL become {SW copies of fill, shiftreg[PW-1:SW]}.
REQ-034 On adv with latched lsbfirst = 0, shiftreg SHALL become {shiftreg[PW-SW-1:0], SW copies of fill}.
REQ-035 While wait_in = 1, dout, count and shiftreg SHALL hold; words SHALL still be accepted into the holding stage.
REQ-036 If count == 1 & adv with no word held or accepted, count SHALL go to 0 and valid_out SHALL drop next cycle.
REQ-037 When an adv and a shifter load happen on the same edge, the load SHALL take precedence over the shift.

Reset
REQ-038 nreset low SHALL asynchronously clear count, hold_valid, shiftreg and held data.
REQ-039 During reset, valid_out = 0, last_out = 0, busy = 0, ready_out = 1 and dout = 0.
REQ-040 Reset mid-word SHALL drop the partial word and any held word, with no further beats after release.
REQ-041 The first valid_in after reset release SHALL be accepted on the first rising edge.

Verification
REQ-042 PW=8, SW=1, din=8'hA5, datasize=0, lsbfirst=1 -> dout 1,0,1,0,0,1,0,1 on 8 consecutive cycles; last_out on the 8th only.
REQ-043 PW=8, SW=2, din=8'hC6, datasize=3, lsbfirst=0, fill=1 -> dout 2'b11,2'b00,2'b01, then valid_out=0.
REQ-044 Back-to-back 8'hFF then 8'h00, valid_in held high -> 16 contiguous valid beats; ready_out low while the holding stage is full.
REQ-045 wait_in=1 for 3 cycles at beat 4 -> beat 4 repeats on dout for those cycles; no beat lost or duplicated after release.
REQ-046 datasize=200 with PW=8, SW=1 -> exactly 8 beats sent.
REQ-047 nreset asserted at beat 3 with a second word held -> outputs at reset values immediately; no beats after release.
